decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 272 +++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: a small circular instruction queue feeding a combinational
// decoder, with a load-use interlock and a skid-free registered output packet.
module decode_stage #(
  parameter int QUEUE_DEPTH = 4,
  parameter int XLEN        = 32
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [31:0]                   in_instr,
  input  logic [XLEN-1:0]               in_pc,
  input  logic                          flush,
  input  logic                          ex_load_valid,
  input  logic [4:0]                    ex_load_rd,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_pc,
  output logic [31:0]                   out_instr,
  output logic [4:0]                    out_rs1,
  output logic [4:0]                    out_rs2,
  output logic [4:0]                    out_rd,
  output logic                          out_rd_we,
  output logic                          out_is_load,
  output logic                          out_is_store,
  output logic                          out_is_branch,
  output logic                          out_is_jump,
  output logic                          out_is_csr,
  output logic                          out_illegal,
  output logic [$clog2(QUEUE_DEPTH):0]  occupancy
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // ---------------------------------------------------------------------------
  // Instruction queue
  // ---------------------------------------------------------------------------
  logic [31:0]      instr_mem [QUEUE_DEPTH];
  logic [XLEN-1:0]  pc_mem    [QUEUE_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  logic             push;
  logic             pop;
  logic             advance;
  logic             hazard;
  logic             head_present;
  logic [31:0]      head_instr;
  logic [XLEN-1:0]  head_pc;

  assign head_present = (count_reg != '0);
  assign head_instr   = instr_mem[rd_ptr_reg];
  assign head_pc      = pc_mem[rd_ptr_reg];

  // in_ready looks at the count only, so a full queue never accepts even while popping
  assign in_ready  = (count_reg < CNT_W'(QUEUE_DEPTH)) && !flush;
  assign push      = in_valid && in_ready;
  assign advance   = head_present && !hazard && (!out_valid || out_ready);
  assign pop       = advance && !flush;
  assign occupancy = count_reg;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      instr_mem[wr_ptr_reg] <= in_instr;
      pc_mem[wr_ptr_reg]    <= in_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Head decode
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       legal;
  logic       use_rs1;
  logic       use_rs2;
  logic       use_rd;
  logic       cls_load;
  logic       cls_store;
  logic       cls_branch;
  logic       cls_jump;
  logic       cls_csr;

  assign opcode = head_instr[6:0];
  assign funct3 = head_instr[14:12];
  assign funct7 = head_instr[31:25];

  always_comb begin
    legal      = 1'b0;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;
    cls_load   = 1'b0;
    cls_store  = 1'b0;
    cls_branch = 1'b0;
    cls_jump   = 1'b0;
    cls_csr    = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        legal  = 1'b1;
        use_rd = 1'b1;
      end
      OP_JAL: begin
        legal    = 1'b1;
        use_rd   = 1'b1;
        cls_jump = 1'b1;
      end
      OP_JALR: begin
        legal    = (funct3 == 3'b000);
        use_rs1  = 1'b1;
        use_rd   = 1'b1;
        cls_jump = 1'b1;
      end
      OP_BRANCH: begin
        legal      = (funct3 != 3'b010) && (funct3 != 3'b011);
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        cls_branch = 1'b1;
      end
      OP_LOAD: begin
        legal    = (funct3 != 3'b011) && (funct3 != 3'b110) && (funct3 != 3'b111);
        use_rs1  = 1'b1;
        use_rd   = 1'b1;
        cls_load = 1'b1;
      end
      OP_STORE: begin
        legal     = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        cls_store = 1'b1;
      end
      OP_IMM: begin
        // only the shift-immediates constrain funct7
        if (funct3 == 3'b001) begin
          legal = (funct7 == F7_ZERO);
        end else if (funct3 == 3'b101) begin
          legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
        end else begin
          legal = 1'b1;
        end
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_REG: begin
        legal   = (funct7 == F7_ZERO) ||
                  ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      OP_FENCE: begin
        legal = (funct3 == 3'b000);
      end
      OP_SYSTEM: begin
        if (funct3 == 3'b000) begin
          // ECALL / EBREAK are the only funct3=0 encodings in the base ISA
          legal = (head_instr[31:7] == 25'h0000000) || (head_instr[31:7] == 25'h0002000);
        end else if (funct3 == 3'b100) begin
          legal = 1'b0;
        end else begin
          legal   = 1'b1;
          cls_csr = 1'b1;
          use_rd  = 1'b1;
          use_rs1 = !funct3[2];
        end
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic [4:0] dec_rd;
  logic       dec_rd_we;

  // Illegal words carry no register references, so they never interlock
  assign dec_rs1   = (legal && use_rs1) ? head_instr[19:15] : 5'd0;
  assign dec_rs2   = (legal && use_rs2) ? head_instr[24:20] : 5'd0;
  assign dec_rd    = (legal && use_rd)  ? head_instr[11:7]  : 5'd0;
  assign dec_rd_we = (dec_rd != 5'd0);

  // Unused source fields are already zero, so a nonzero load rd can only match real uses
  assign hazard = head_present && ex_load_valid && (ex_load_rd != 5'd0) &&
                  ((dec_rs1 == ex_load_rd) || (dec_rs2 == ex_load_rd));

  // ---------------------------------------------------------------------------
  // Output packet register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_instr     <= '0;
      out_rs1       <= '0;
      out_rs2       <= '0;
      out_rd        <= '0;
      out_rd_we     <= 1'b0;
      out_is_load   <= 1'b0;
      out_is_store  <= 1'b0;
      out_is_branch <= 1'b0;
      out_is_jump   <= 1'b0;
      out_is_csr    <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid     <= 1'b1;
      out_pc        <= head_pc;
      out_instr     <= head_instr;
      out_rs1       <= dec_rs1;
      out_rs2       <= dec_rs2;
      out_rd        <= dec_rd;
      out_rd_we     <= dec_rd_we;
      out_is_load   <= legal && cls_load;
      out_is_store  <= legal && cls_store;
      out_is_branch <= legal && cls_branch;
      out_is_jump   <= legal && cls_jump;
      out_is_csr    <= legal && cls_csr;
      out_illegal   <= !legal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage: a queue-level reference model predicts handshakes,
// and a scoreboard of decoded packets is checked by an independent output monitor.
module tb_decode_stage;

  localparam int D = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        ex_load_valid;
  logic [4:0]  ex_load_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rd_we, out_is_load, out_is_store, out_is_branch, out_is_jump, out_is_csr;
  logic        out_illegal;
  logic [$clog2(D):0] occupancy;

  decode_stage #(.QUEUE_DEPTH(D), .XLEN(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_is_load(out_is_load), .out_is_store(out_is_store), .out_is_branch(out_is_branch),
    .out_is_jump(out_is_jump), .out_is_csr(out_is_csr), .out_illegal(out_illegal),
    .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_we, load, store, branch, jump, csr, illegal;
  } pkt_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  pkt_t   sb[$];
  entry_t mq[$];
  bit     mv;

  int checks = 0;
  int errors = 0;

  bit          run_checks = 0;
  bit          final_req  = 0;
  bit          mon_done   = 0;
  bit          pending_clear = 0;
  bit          prev_reset = 0;
  bit          exp_in_ready, exp_ov, exp_zero;
  int          exp_occ;
  logic [31:0] cur_instr, cur_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference decode straight from the ISA tables
  function automatic pkt_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    pkt_t p;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    bit legal, r1, r2, rdu;
    p = '0;
    p.pc = pc;
    p.instr = w;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    legal = 0; r1 = 0; r2 = 0; rdu = 0;
    case (op)
      7'h37, 7'h17: begin legal = 1; rdu = 1; end
      7'h6f: begin legal = 1; rdu = 1; p.jump = 1; end
      7'h67: begin legal = (f3 == 0); r1 = 1; rdu = 1; p.jump = 1; end
      7'h63: begin legal = !(f3 inside {3'd2, 3'd3}); r1 = 1; r2 = 1; p.branch = 1; end
      7'h03: begin legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); r1 = 1; rdu = 1; p.load = 1; end
      7'h23: begin legal = (f3 < 3); r1 = 1; r2 = 1; p.store = 1; end
      7'h13: begin
        legal = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 inside {7'd0, 7'd32}) : 1'b1;
        r1 = 1; rdu = 1;
      end
      7'h33: begin
        legal = (f7 == 0) || ((f7 == 32) && (f3 inside {3'd0, 3'd5}));
        r1 = 1; r2 = 1; rdu = 1;
      end
      7'h0f: legal = (f3 == 0);
      7'h73: begin
        if (f3 == 0) legal = (w == 32'h0000_0073) || (w == 32'h0010_0073);
        else if (f3 == 4) legal = 0;
        else begin legal = 1; p.csr = 1; rdu = 1; r1 = (f3 < 4); end
      end
      default: legal = 0;
    endcase
    if (legal) begin
      p.rs1 = r1 ? w[19:15] : 5'd0;
      p.rs2 = r2 ? w[24:20] : 5'd0;
      p.rd  = rdu ? w[11:7] : 5'd0;
      p.rd_we = (p.rd != 0);
    end else begin
      {p.load, p.store, p.branch, p.jump, p.csr} = '0;
      p.illegal = 1;
    end
    return p;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [4:0]  a, b, d;
    logic [11:0] imm;
    logic [2:0]  f3;
    a = 5'($urandom_range(0, 3));
    b = 5'($urandom_range(0, 3));
    d = 5'($urandom_range(0, 3));
    imm = 12'($urandom);
    f3 = 3'($urandom);
    case ($urandom_range(0, 13))
      0:  return {imm, a, 3'b000, d, 7'h13};
      1:  return {($urandom_range(0, 3) == 0 ? 7'h20 : 7'h00), b, a, f3, d, 7'h33};
      2:  return {20'($urandom), d, 7'h37};
      3:  return {imm, a, f3, d, 7'h03};
      4:  return {imm[11:5], b, a, f3, imm[4:0], 7'h23};
      5:  return {imm[11:5], b, a, f3, imm[4:0], 7'h63};
      6:  return {20'($urandom), d, 7'h6f};
      7:  return {imm, a, ($urandom_range(0, 3) == 0 ? f3 : 3'b000), d, 7'h67};
      8:  return {imm, a, f3, d, 7'h73};
      9:  return 32'h0000_0000;
      10: return $urandom;
      11: return {($urandom_range(0, 2) == 0 ? 7'h01 : 7'h20), b, a,
                  ($urandom_range(0, 1) == 0 ? 3'b001 : 3'b101), d, 7'h13};
      12: return ($urandom_range(0, 1) == 0) ? 32'h0000_0073 : 32'h0010_0073;
      default: return {imm, 5'd0, 3'b000, 5'd0, 7'h0f};
    endcase
  endfunction

  // One clock of stimulus plus the reference model's view of that cycle
  task automatic step(input int pv, input int pr, input int pl, input int pf, input int prst);
    bit push, head, hz, adv;
    pkt_t h;
    @(posedge clock);
    #1;
    if (pending_clear) begin
      sb.delete();
      pending_clear = 0;
    end
    in_valid      = ($urandom_range(0, 99) < pv);
    out_ready     = ($urandom_range(0, 99) < pr);
    ex_load_valid = ($urandom_range(0, 99) < pl);
    ex_load_rd    = 5'($urandom_range(0, 3));
    flush         = ($urandom_range(0, 99) < pf);
    reset         = ($urandom_range(0, 99) < prst);
    in_instr      = cur_instr;
    in_pc         = cur_pc;

    exp_zero     = prev_reset;
    prev_reset   = reset;
    exp_in_ready = (mq.size() < D) && !flush;
    exp_occ      = mq.size();
    exp_ov       = mv;

    push = in_valid && exp_in_ready;
    head = (mq.size() > 0);
    hz = 0;
    if (head) begin
      h = ref_decode(mq[0].instr, mq[0].pc);
      hz = ex_load_valid && (ex_load_rd != 0) && ((h.rs1 == ex_load_rd) || (h.rs2 == ex_load_rd));
    end
    adv = head && !hz && (!mv || out_ready);

    if (reset || flush) begin
      mq.delete();
      mv = 0;
      pending_clear = 1;
    end else begin
      if (adv) begin
        void'(mq.pop_front());
        mv = 1;
      end else if (mv && out_ready) begin
        mv = 0;
      end
      if (push) begin
        mq.push_back('{instr: cur_instr, pc: cur_pc});
        sb.push_back(ref_decode(cur_instr, cur_pc));
        cur_pc    = cur_pc + 32'd4;
        cur_instr = gen_instr();
      end
    end
  endtask

  // Output monitor: handshake expectations every cycle, packet contents from the scoreboard
  always @(negedge clock) begin
    pkt_t e;
    if (run_checks) begin
      check("in_ready", 64'(in_ready), 64'(exp_in_ready));
      check("occupancy", 64'(occupancy), 64'(exp_occ));
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      if (exp_zero) begin
        check("reset_fields", {out_pc, out_instr},
              64'({out_rs1, out_rs2, out_rd, out_rd_we, out_is_load, out_is_store,
                   out_is_branch, out_is_jump, out_is_csr, out_illegal} & 22'h0));
        check("reset_ctl", 64'({out_rs1, out_rs2, out_rd, out_rd_we, out_is_load, out_is_store,
                                out_is_branch, out_is_jump, out_is_csr, out_illegal}), 64'd0);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_packet actual pc=%0h required none at %0t", out_pc, $time);
        end else begin
          e = sb[0];
          check("pkt_pc", 64'(out_pc), 64'(e.pc));
          check("pkt_instr", 64'(out_instr), 64'(e.instr));
          check("pkt_regs", 64'({out_rs1, out_rs2, out_rd}), 64'({e.rs1, e.rs2, e.rd}));
          check("pkt_ctl",
                64'({out_rd_we, out_is_load, out_is_store, out_is_branch, out_is_jump, out_is_csr, out_illegal}),
                64'({e.rd_we, e.load, e.store, e.branch, e.jump, e.csr, e.illegal}));
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
    if (final_req && !mon_done) begin
      check("drain_empty", 64'(sb.size()), 64'd0);
      mon_done = 1;
    end
  end

  initial begin
    reset = 1; in_valid = 0; in_instr = 0; in_pc = 0; flush = 0;
    ex_load_valid = 0; ex_load_rd = 0; out_ready = 0;
    cur_pc = 32'h0;
    cur_instr = gen_instr();
    mv = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    exp_zero = 1; exp_in_ready = 1; exp_occ = 0; exp_ov = 0;
    prev_reset = 0;
    run_checks = 1;

    repeat (200) step(100, 100, 0, 0, 0);    // streaming, no stalls
    repeat (300) step(90, 15, 0, 0, 0);      // heavy back-pressure, queue full
    repeat (400) step(80, 70, 50, 0, 0);     // load-use interlocks
    repeat (1000) step(70, 60, 30, 5, 2);    // everything incl. flush and reset
    repeat (4 * D + 8) step(0, 100, 0, 0, 0); // drain

    @(posedge clock);
    #1;
    run_checks = 0;
    final_req = 1;
    for (int i = 0; i < 5 && !mon_done; i++) @(negedge clock);
    if (!mon_done) begin
      $display("FAIL monitor_timeout actual=pending required=done");
      $fatal(1, "monitor did not finish");
    end
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
